hht_spmv_engine: RTL and testbench
==================================

HHT_SPMV_ENGINE -- requirements
Module: hht_spmv_engine

Interface
REQ-001 Parameter DW, default 32, data width of matrix values, vector values, column indices and row pointers.
REQ-002 Parameter AW, default 32, memory address width.
REQ-003 Parameter ACCW, default 64, accumulator and result width (ACCW >= 2*DW).
REQ-004 Parameter RW, default 16, row-count and row-index width.
REQ-005 Clk  in  1  single clock; all state updates on the rising edge.
REQ-006 Rst  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  one-cycle job request; sampled only in IDLE.
REQ-008 row_base, col_base, val_base, vec_base  in  AW each  base addresses of the CSR row-pointer, column-index, value and dense-vector arrays.
REQ-009 num_rows  in  RW  number of matrix rows; latched with start.
REQ-010 addr1  out  AW  port-1 read address (row pointers, column indices).
REQ-011 dataIn1  in  DW  port-1 read data, combinational from addr1 in the same cycle.
REQ-012 addr2  out  AW  port-2 read address (values, vector).
REQ-013 dataIn2  in  DW  port-2 read data, combinational from addr2 in the same cycle.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 done  out  1  one-cycle pulse at job end.
REQ-016 err  out  1  sticky malformed-row-pointer flag; cleared on the next accepted start.
REQ-017 y_valid  out  1, y_ready  in  1, y_row  out  RW, y_data  out  ACCW  result stream with a valid/ready handshake.

Function
REQ-018 The block SHALL compute y[r] = sum over k in [rowptr[r], rowptr[r+1]) of val[k]*vec[col[k]], for r = 0..num_rows-1, in ascending row order.
REQ-019 The FSM states SHALL be IDLE, RPTR0, RPTR, FETCH, VEC, EMIT, DONE.
REQ-020 IDLE -> RPTR0 on start; the base addresses and num_rows SHALL be latched on the same edge.
REQ-021 RPTR0: addr1 = row_base; latch cur_ptr = dataIn1; clear the accumulator; -> RPTR. If num_rows = 0, -> DONE instead.
REQ-022 RPTR: addr1 = row_base + r + 1; latch end_ptr = dataIn1.
  - end_ptr < cur_ptr: set err, -> DONE.
  - end_ptr = cur_ptr: -> EMIT.
  - otherwise: -> FETCH.
REQ-023 FETCH: addr1 = col_base + cur_ptr, addr2 = val_base + cur_ptr; latch col and val; -> VEC.
REQ-024 VEC: addr2 = vec_base + col; acc += val * dataIn2; increment cur_ptr.
  - cur_ptr + 1 = end_ptr: -> EMIT.
  - otherwise: -> FETCH.
REQ-025 Arithmetic SHALL be unsigned: the product is 2*DW bits, zero-extended to ACCW, and accumulated modulo 2^ACCW.
REQ-026 EMIT: y_valid = 1, y_row = r, y_data = acc.
  - These outputs SHALL stay stable until the cycle in which y_ready = 1.
  - In that cycle: clear acc, r++, cur_ptr keeps end_ptr; then -> RPTR, or -> DONE if r + 1 = num_rows.
REQ-027 DONE: done = 1 for exactly one cycle; -> IDLE.
REQ-028 A start asserted while busy SHALL be ignored.
REQ-029 With y_ready held high, a row with n nonzeros SHALL take 2 + 2n cycles (RPTR, n x FETCH/VEC, EMIT).
REQ-030 A complete job with y_ready held high SHALL take 2 + sum(2 + 2n_r) cycles from the start edge up to and including the DONE cycle.
REQ-031 When not addressed by the current state, addr1 and addr2 SHALL be 0.

Reset
REQ-032 Assertion of Rst low SHALL force, asynchronously:
  - state = IDLE;
  - busy = done = err = y_valid = 0;
  - y_row = y_data = addr1 = addr2 = 0;
  - acc = r = cur_ptr = end_ptr = 0.
REQ-033 A reset mid-job SHALL abandon the job with no further y_valid or done; the next start SHALL begin a fresh job.

Structure
REQ-034 The package hht_pkg SHALL hold the state enum and the default parameter constants.
REQ-035 The multiply-accumulate datapath SHALL be one sub-module, hht_mac (inputs: clear, enable, a, b; output: acc).

Verification
REQ-036 The bench SHALL cover these directed scenarios:
  - 2x2 job: rowptr {0,1,3}, col {1,0,1}, val {2,3,4}, vec {5,6}, y_ready = 1 -> y (0,12) then (1,39); done pulses 12 cycles after the start edge; err = 0.
  - Empty row: rowptr {0,0,2}, col {0,1}, val {7,1}, vec {2,3} -> y (0,0) then (1,17).
  - Malformed pointers: rowptr {0,3,1} -> row 0 emitted; err = 1 with done; no row-1 output; err clears on the next start.
  - Backpressure: 2x2 job with y_ready low for 3 cycles during row 0 -> y_valid, y_row = 0 and y_data = 12 held stable; total time +3 cycles.
  - Overflow and zero-row job: val = vec = 2^32-1 with two nonzeros and ACCW = 64 -> y = 0x1_FFFF_FFFC_0000_0002; num_rows = 0 -> done 2 cycles after start, no y_valid.
  - Reset and start-while-busy: Rst low in a VEC cycle -> all outputs 0 immediately, no done; a start pulse while busy has no effect.

Source files
------------

// File: rtl/hht_pkg.sv
// Shared types and default parameters for the CSR sparse matrix-vector engine.
package hht_pkg;

   localparam int unsigned DW_DEF   = 32;
   localparam int unsigned AW_DEF   = 32;
   localparam int unsigned ACCW_DEF = 64;
   localparam int unsigned RW_DEF   = 16;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RPTR0 = 3'd1,
      S_RPTR  = 3'd2,
      S_FETCH = 3'd3,
      S_VEC   = 3'd4,
      S_EMIT  = 3'd5,
      S_DONE  = 3'd6
   } state_e;

endpackage

// File: rtl/hht_mac.sv
// Unsigned multiply-accumulate: full-width product, wrap-around accumulation.
module hht_mac
   import hht_pkg::*;
#(
   parameter int unsigned DW   = DW_DEF,
   parameter int unsigned ACCW = ACCW_DEF
) (
   input  logic            Clk,
   input  logic            Rst,
   input  logic            clear,
   input  logic            enable,
   input  logic [DW-1:0]   a,
   input  logic [DW-1:0]   b,
   output logic [ACCW-1:0] acc
);

   localparam int unsigned PW = 2 * DW;

   logic [PW-1:0] prod;

   assign prod = PW'(a) * PW'(b);

   // clear wins over enable so a row restart never folds in a stale product
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst)        acc <= '0;
      else if (clear)  acc <= '0;
      else if (enable) acc <= acc + ACCW'(prod);
   end

endmodule

// File: rtl/hht_spmv_engine.sv
// CSR sparse matrix times dense vector; streams one result per row in ascending order.
module hht_spmv_engine
   import hht_pkg::*;
#(
   parameter int unsigned DW   = DW_DEF,
   parameter int unsigned AW   = AW_DEF,
   parameter int unsigned ACCW = ACCW_DEF,
   parameter int unsigned RW   = RW_DEF
) (
   input  logic            Clk,
   input  logic            Rst,
   input  logic            start,
   input  logic [AW-1:0]   row_base,
   input  logic [AW-1:0]   col_base,
   input  logic [AW-1:0]   val_base,
   input  logic [AW-1:0]   vec_base,
   input  logic [RW-1:0]   num_rows,
   output logic [AW-1:0]   addr1,
   input  logic [DW-1:0]   dataIn1,
   output logic [AW-1:0]   addr2,
   input  logic [DW-1:0]   dataIn2,
   output logic            busy,
   output logic            done,
   output logic            err,
   output logic            y_valid,
   input  logic            y_ready,
   output logic [RW-1:0]   y_row,
   output logic [ACCW-1:0] y_data
);

   state_e          state, state_nxt;
   logic [AW-1:0]   row_base_q, col_base_q, val_base_q, vec_base_q;
   logic [RW-1:0]   num_rows_q;
   logic [RW-1:0]   r;
   logic [DW-1:0]   cur_ptr, end_ptr, col_q, val_q;
   logic            mac_clear, mac_en;
   logic [ACCW-1:0] acc;

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // Next state plus the same-cycle memory addresses and MAC controls
   always_comb begin
      state_nxt = state;
      addr1     = '0;
      addr2     = '0;
      mac_clear = 1'b0;
      mac_en    = 1'b0;
      case (state)
         S_IDLE:  if (start) state_nxt = S_RPTR0;
         S_RPTR0: begin
            addr1     = row_base_q;
            mac_clear = 1'b1;
            state_nxt = (num_rows_q == '0) ? S_DONE : S_RPTR;
         end
         S_RPTR: begin
            addr1 = row_base_q + AW'(r) + AW'(1);
            if (dataIn1 < cur_ptr)       state_nxt = S_DONE;
            else if (dataIn1 == cur_ptr) state_nxt = S_EMIT;
            else                         state_nxt = S_FETCH;
         end
         S_FETCH: begin
            addr1     = col_base_q + AW'(cur_ptr);
            addr2     = val_base_q + AW'(cur_ptr);
            state_nxt = S_VEC;
         end
         S_VEC: begin
            addr2     = vec_base_q + AW'(col_q);
            mac_en    = 1'b1;
            state_nxt = ((cur_ptr + DW'(1)) == end_ptr) ? S_EMIT : S_FETCH;
         end
         S_EMIT: begin
            if (y_ready) begin
               mac_clear = 1'b1;
               state_nxt = ((r + RW'(1)) == num_rows_q) ? S_DONE : S_RPTR;
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         row_base_q <= '0;
         col_base_q <= '0;
         val_base_q <= '0;
         vec_base_q <= '0;
         num_rows_q <= '0;
         r          <= '0;
         cur_ptr    <= '0;
         end_ptr    <= '0;
         col_q      <= '0;
         val_q      <= '0;
         err        <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         y_valid    <= 1'b0;
      end else begin
         busy    <= (state_nxt != S_IDLE);
         done    <= (state_nxt == S_DONE);
         y_valid <= (state_nxt == S_EMIT);
         case (state)
            S_IDLE: begin
               if (start) begin
                  row_base_q <= row_base;
                  col_base_q <= col_base;
                  val_base_q <= val_base;
                  vec_base_q <= vec_base;
                  num_rows_q <= num_rows;
                  r          <= '0;
                  err        <= 1'b0;
               end
            end
            S_RPTR0: cur_ptr <= dataIn1;
            S_RPTR: begin
               end_ptr <= dataIn1;
               if (dataIn1 < cur_ptr) err <= 1'b1;
            end
            S_FETCH: begin
               col_q <= dataIn1;
               val_q <= dataIn2;
            end
            S_VEC:   cur_ptr <= cur_ptr + DW'(1);
            S_EMIT: begin
               if (y_ready) begin
                  r       <= r + RW'(1);
                  cur_ptr <= end_ptr;
               end
            end
            default: ;
         endcase
      end
   end

   hht_mac #(
      .DW   (DW),
      .ACCW (ACCW)
   ) u_mac (
      .Clk    (Clk),
      .Rst    (Rst),
      .clear  (mac_clear),
      .enable (mac_en),
      .a      (val_q),
      .b      (dataIn2),
      .acc    (acc)
   );

   assign y_row  = r;
   assign y_data = acc;

endmodule

// File: tb/tb_hht_spmv_engine.sv
// Directed bench for hht_spmv_engine: table of CSR jobs plus reset / start-while-busy sequences.
module tb_hht_spmv_engine;

   logic        Clk, Rst, start, y_ready;
   logic [31:0] row_base, col_base, val_base, vec_base;
   logic [15:0] num_rows;
   logic [31:0] addr1, addr2, dataIn1, dataIn2;
   logic        busy, done, err, y_valid;
   logic [15:0] y_row;
   logic [63:0] y_data;

   logic [31:0] mem [0:255];

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int          nr;
      logic [31:0] rp  [4];
      logic [31:0] col [4];
      logic [31:0] val [4];
      logic [31:0] vec [4];
      int          ny;
      logic [63:0] ey  [3];
      logic        eerr;
      int          ecyc;
   } job_t;

   job_t jobs [6];

   hht_spmv_engine dut (
      .Clk      (Clk),
      .Rst      (Rst),
      .start    (start),
      .row_base (row_base),
      .col_base (col_base),
      .val_base (val_base),
      .vec_base (vec_base),
      .num_rows (num_rows),
      .addr1    (addr1),
      .dataIn1  (dataIn1),
      .addr2    (addr2),
      .dataIn2  (dataIn2),
      .busy     (busy),
      .done     (done),
      .err      (err),
      .y_valid  (y_valid),
      .y_ready  (y_ready),
      .y_row    (y_row),
      .y_data   (y_data)
   );

   assign dataIn1 = mem[addr1[7:0]];
   assign dataIn2 = mem[addr2[7:0]];

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic load(input int j);
      for (int i = 0; i < 4; i++) begin
         mem[i]      = jobs[j].rp[i];
         mem[32 + i] = jobs[j].col[i];
         mem[64 + i] = jobs[j].val[i];
         mem[96 + i] = jobs[j].vec[i];
      end
   endtask

   // Runs one job; bp stalls the first result, mid_start pulses start at that cycle
   task automatic run_job(input int j, input int bp, input int mid_start);
      int   cyc, nout, stalls;
      bit   done_seen, busy_ok;
      load(j);
      @(negedge Clk);
      num_rows = 16'(jobs[j].nr);
      start    = 1'b1;
      y_ready  = 1'b1;
      @(negedge Clk);
      start     = 1'b0;
      cyc       = 1;
      nout      = 0;
      stalls    = 0;
      done_seen = 1'b0;
      busy_ok   = 1'b1;
      chk($sformatf("job%0d_err_cleared", j), 64'(err), 64'd0);
      while (!done_seen && cyc < 200) begin
         if (!busy) busy_ok = 1'b0;
         if (y_valid) begin
            if (nout < jobs[j].ny) begin
               chk($sformatf("job%0d_y_row%0d", j, nout), 64'(y_row), 64'(nout));
               chk($sformatf("job%0d_y_data%0d", j, nout), y_data, jobs[j].ey[nout]);
            end else begin
               chk($sformatf("job%0d_extra_y_valid", j), 64'(y_valid), 64'd0);
            end
            if (nout == 0 && stalls < bp) begin
               y_ready = 1'b0;
               stalls++;
            end else begin
               y_ready = 1'b1;
               nout++;
            end
         end else begin
            y_ready = 1'b1;
         end
         if (done) begin
            done_seen = 1'b1;
            chk($sformatf("job%0d_done_cycle", j), 64'(cyc), 64'(jobs[j].ecyc + bp));
            chk($sformatf("job%0d_err", j), 64'(err), 64'(jobs[j].eerr));
            chk($sformatf("job%0d_num_results", j), 64'(nout), 64'(jobs[j].ny));
         end
         start = (mid_start != 0 && cyc == mid_start);
         if (!done_seen) begin
            @(negedge Clk);
            cyc++;
         end
      end
      start = 1'b0;
      if (!done_seen) chk($sformatf("job%0d_done_timeout", j), 64'(done_seen), 64'd1);
      chk($sformatf("job%0d_busy_throughout", j), 64'(busy_ok), 64'd1);
      @(negedge Clk);
      chk($sformatf("job%0d_done_one_cycle", j), 64'(done), 64'd0);
      chk($sformatf("job%0d_idle_busy", j), 64'(busy), 64'd0);
      chk($sformatf("job%0d_idle_y_valid", j), 64'(y_valid), 64'd0);
   endtask

   task automatic reset_outputs_zero(input string tag);
      chk({tag, "_busy"},    64'(busy),    64'd0);
      chk({tag, "_done"},    64'(done),    64'd0);
      chk({tag, "_err"},     64'(err),     64'd0);
      chk({tag, "_y_valid"}, 64'(y_valid), 64'd0);
      chk({tag, "_y_row"},   64'(y_row),   64'd0);
      chk({tag, "_y_data"},  y_data,       64'd0);
      chk({tag, "_addr1"},   64'(addr1),   64'd0);
      chk({tag, "_addr2"},   64'(addr2),   64'd0);
   endtask

   task automatic reset_mid_job();
      int  n;
      bit  in_vec;
      load(0);
      @(negedge Clk);
      num_rows = 16'd2;
      start    = 1'b1;
      y_ready  = 1'b1;
      @(negedge Clk);
      start  = 1'b0;
      in_vec = 1'b0;
      n      = 0;
      while (!in_vec && n < 50) begin
         if (addr2 >= 32'h60 && addr2 < 32'h70) in_vec = 1'b1;
         else begin
            @(negedge Clk);
            n++;
         end
      end
      chk("rst_reached_vec", 64'(in_vec), 64'd1);
      Rst = 1'b0;
      #1;
      reset_outputs_zero("rst_mid");
      for (int i = 0; i < 3; i++) begin
         @(negedge Clk);
         chk("rst_hold_done",    64'(done),    64'd0);
         chk("rst_hold_y_valid", 64'(y_valid), 64'd0);
      end
      Rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge Clk);
         chk("post_rst_no_done", 64'(done), 64'd0);
         chk("post_rst_idle",    64'(busy), 64'd0);
      end
   endtask

   initial begin
      jobs[0].nr = 2; jobs[0].rp = '{0, 1, 3, 0}; jobs[0].col = '{1, 0, 1, 0};
      jobs[0].val = '{2, 3, 4, 0}; jobs[0].vec = '{5, 6, 0, 0};
      jobs[0].ny = 2; jobs[0].ey = '{64'd12, 64'd39, 64'd0}; jobs[0].eerr = 1'b0; jobs[0].ecyc = 12;

      jobs[1].nr = 2; jobs[1].rp = '{0, 0, 2, 0}; jobs[1].col = '{0, 1, 0, 0};
      jobs[1].val = '{7, 1, 0, 0}; jobs[1].vec = '{2, 3, 0, 0};
      jobs[1].ny = 2; jobs[1].ey = '{64'd0, 64'd17, 64'd0}; jobs[1].eerr = 1'b0; jobs[1].ecyc = 10;

      // row 1 pointer goes backwards: row 0 (3 nonzeros) emits, then err + done
      jobs[2].nr = 2; jobs[2].rp = '{0, 3, 1, 0}; jobs[2].col = '{0, 1, 0, 0};
      jobs[2].val = '{1, 1, 1, 0}; jobs[2].vec = '{5, 6, 0, 0};
      jobs[2].ny = 1; jobs[2].ey = '{64'd16, 64'd0, 64'd0}; jobs[2].eerr = 1'b1; jobs[2].ecyc = 11;

      // 2*(2^32-1)^2 = 0x1_FFFF_FFFC_0000_0002, kept modulo 2^64
      jobs[3].nr = 1; jobs[3].rp = '{0, 2, 0, 0}; jobs[3].col = '{0, 0, 0, 0};
      jobs[3].val = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0}; jobs[3].vec = '{32'hFFFF_FFFF, 0, 0, 0};
      jobs[3].ny = 1; jobs[3].ey = '{64'hFFFF_FFFC_0000_0002, 64'd0, 64'd0}; jobs[3].eerr = 1'b0; jobs[3].ecyc = 8;

      jobs[4].nr = 0; jobs[4].rp = '{0, 0, 0, 0}; jobs[4].col = '{0, 0, 0, 0};
      jobs[4].val = '{0, 0, 0, 0}; jobs[4].vec = '{0, 0, 0, 0};
      jobs[4].ny = 0; jobs[4].ey = '{64'd0, 64'd0, 64'd0}; jobs[4].eerr = 1'b0; jobs[4].ecyc = 2;

      jobs[5].nr = 3; jobs[5].rp = '{0, 1, 2, 3}; jobs[5].col = '{0, 1, 1, 0};
      jobs[5].val = '{1, 2, 3, 0}; jobs[5].vec = '{9, 4, 0, 0};
      jobs[5].ny = 3; jobs[5].ey = '{64'd9, 64'd8, 64'd12}; jobs[5].eerr = 1'b0; jobs[5].ecyc = 14;

      for (int i = 0; i < 256; i++) mem[i] = '0;
      Rst      = 1'b0;
      start    = 1'b0;
      y_ready  = 1'b1;
      num_rows = '0;
      row_base = 32'h00;
      col_base = 32'h20;
      val_base = 32'h40;
      vec_base = 32'h60;
      #1;
      reset_outputs_zero("por");
      repeat (3) @(negedge Clk);
      Rst = 1'b1;
      @(negedge Clk);
      chk("idle_after_reset_busy", 64'(busy), 64'd0);

      run_job(0, 0, 0);
      run_job(0, 3, 0);
      run_job(1, 0, 0);
      run_job(2, 0, 0);
      run_job(3, 0, 0);
      run_job(4, 0, 0);
      run_job(5, 0, 0);
      run_job(0, 0, 3);
      reset_mid_job();
      run_job(0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
